// File: rtl/cdm_pkg.sv
// Shared widths, types and small datapath helpers for the CDM8 approximate multiplier.
package cdm_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 16;
  localparam int CDM_K = 5;

  typedef logic [OP_W-1:0]  op_t;
  typedef logic [RES_W-1:0] res_t;

  // Carry-save pair produced by one 3:2 compression layer.
  typedef struct packed {
    res_t sum;
    res_t carry;
  } csa_t;

  // Row of full adders: three addends in, sum/carry pair out.
  // The carry bit shifted out of the top is dropped. The high field never exceeds 16 bits,
  // so the modulo-2^16 result is still exact.
  function automatic csa_t csa3(res_t x, res_t y, res_t z);
    csa_t r;
    r.sum   = x ^ y ^ z;
    r.carry = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction

  // Partial-product row for multiplier bit j, placed at its column weight.
  // Only the exact columns (i+j >= CDM_K) are kept.
  function automatic res_t pp_row_hi(op_t a, logic b_bit, int j);
    res_t r;
    r = '0;
    for (int i = 0; i < OP_W; i++) begin
      if (i + j >= CDM_K) begin
        r = r | (res_t'(a[i] & b_bit) << (i + j));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cdm8_51_comb.sv
// Combinational core of the CDM8 variant 51 multiplier. The low columns are OR-reduced with no carries.
// The high columns are summed exactly by a Wallace carry-save tree and a final ripple adder.
module cdm8_51_comb
  import cdm_pkg::*;
(
  input  op_t  a_i,
  input  op_t  b_i,
  output res_t r_o
);

  res_t             rows [OP_W];
  logic [CDM_K-1:0] lo;
  res_t             hi;
  csa_t             l1a, l1b, l2a, l2b, l3, l4;

  // Build the masked partial-product rows for the exact field.
  always_comb begin
    for (int j = 0; j < OP_W; j++) begin
      rows[j] = pp_row_hi(a_i, b_i[j], j);
    end
  end

  // Carry-disregard low field: each column is the OR of its partial products.
  always_comb begin
    lo = '0;
    for (int i = 0; i < OP_W; i++) begin
      for (int j = 0; j < OP_W; j++) begin
        if (i + j < CDM_K) begin
          lo = lo | ({{(CDM_K-1){1'b0}}, a_i[i] & b_i[j]} << (i + j));
        end
      end
    end
  end

  // Wallace reduction of eight rows: 8 -> 6 -> 4 -> 3 -> 2.
  assign l1a = csa3(rows[0], rows[1], rows[2]);
  assign l1b = csa3(rows[3], rows[4], rows[5]);
  assign l2a = csa3(l1a.sum, l1a.carry, l1b.sum);
  assign l2b = csa3(l1b.carry, rows[6], rows[7]);
  assign l3  = csa3(l2a.sum, l2a.carry, l2b.sum);
  assign l4  = csa3(l3.sum, l3.carry, l2b.carry);

  // Final ripple-carry adder merging the last sum/carry pair.
  always_comb begin
    logic cy;
    cy = 1'b0;
    hi = '0;
    for (int k = 0; k < RES_W; k++) begin
      hi[k] = l4.sum[k] ^ l4.carry[k] ^ cy;
      cy    = (l4.sum[k] & l4.carry[k]) | (l4.sum[k] & cy) | (l4.carry[k] & cy);
    end
  end

  // The high field is a multiple of 2^CDM_K, so OR-ing in the low field cannot collide.
  assign r_o = hi | {{(RES_W-CDM_K){1'b0}}, lo};

endmodule

// File: rtl/cdm8_51_mul.sv
// CDM8 variant 51 approximate 8x8 multiplier with a registered 16-bit product.
// The operands are sampled every edge. R shows the result of that sample after one edge.
module cdm8_51_mul
  import cdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  A,
  input  logic [OP_W-1:0]  B,
  output logic [RES_W-1:0] R
);

  res_t r_d;
  res_t r_q;

  cdm8_51_comb u_comb (
    .a_i (A),
    .b_i (B),
    .r_o (r_d)
  );

  // Product register. Reset clears it at once and drops any in-flight sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign R = r_q;

endmodule

// File: tb/tb_cdm8_51_mul.sv
// Scoreboard bench for cdm8_51_mul: directed, pipelined, reset and exhaustive cases.
module tb_cdm8_51_mul;

  logic        clk;
  logic        rst;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] R;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    bit          le;
  } item_t;

  item_t q[$];
  string tag_q[$];

  cdm8_51_mul dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .R   (R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, int obs, int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bit-level model: OR of the low columns, exact integer sum of the high columns.
  function automatic logic [15:0] ref_mul(logic [7:0] a, logic [7:0] b);
    int         h;
    logic [4:0] l;
    h = 0;
    l = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (a[i] && b[j]) begin
          if (i + j >= 5) h = h + (1 << (i + j));
          else            l = l | (5'd1 << (i + j));
        end
      end
    end
    return h[15:0] | {11'b0, l};
  endfunction

  task automatic compare_one();
    item_t t;
    string tg;
    t  = q.pop_front();
    tg = tag_q.pop_front();
    chk(tg, int'(R), int'(t.exp));
    if (t.le) chk({tg, "_le"}, int'(int'(R) <= int'(t.a) * int'(t.b)), 1);
  endtask

  // At the falling edge: check the result captured at the last rising edge, then drive the next pair.
  task automatic step(logic [7:0] a, logic [7:0] b, logic [15:0] exp, bit le, string tag);
    item_t t;
    @(negedge clk);
    if (q.size() > 0) compare_one();
    A = a;
    B = b;
    t.a = a; t.b = b; t.exp = exp; t.le = le;
    q.push_back(t);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    while (q.size() > 0) begin
      @(negedge clk);
      compare_one();
    end
  endtask

  initial begin
    item_t t;
    logic [7:0] ra, rb;
    rst = 1'b1;
    A   = 8'hFF;
    B   = 8'hFF;

    @(negedge clk);
    @(negedge clk);
    chk("rst_init", int'(R), 0);

    // Release reset at a falling edge; the next rising edge captures FF*FF.
    rst = 1'b0;
    t.a = 8'hFF; t.b = 8'hFF; t.exp = 16'd64927; t.le = 1'b1;
    q.push_back(t);
    tag_q.push_back("rst_release");

    step(8'd0,   8'd173, 16'd0,     1'b1, "zero");
    step(8'd1,   8'd1,   16'd1,     1'b1, "one");
    step(8'd31,  8'd1,   16'd31,    1'b1, "id31");
    step(8'd3,   8'd3,   16'd7,     1'b1, "cd3x3");
    step(8'd7,   8'd7,   16'd31,    1'b1, "cd7x7");
    step(8'd32,  8'd1,   16'd32,    1'b1, "hi32");
    step(8'd16,  8'd16,  16'd256,   1'b1, "hi16x16");
    step(8'd255, 8'd255, 16'd64927, 1'b1, "max");

    // Back-to-back random pairs, no bubbles.
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      step(ra, rb, ref_mul(ra, rb), 1'b1, "pipe");
    end

    // Mid-stream reset: R has to clear before the next edge, and the in-flight sample is lost.
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", int'(R), 0);
    q.delete();
    tag_q.delete();
    @(negedge clk);
    chk("rst_hold", int'(R), 0);
    rst = 1'b0;

    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      step(ra, rb, ref_mul(ra, rb), 1'b1, "restart");
    end

    // Exhaustive sweep, one pair per cycle.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        ra = 8'(a);
        rb = 8'(b);
        step(ra, rb, ref_mul(ra, rb), 1'b1, "exh");
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
